// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver that reassembles 64 consecutive bytes little-endian into a 512-bit word.
// Partial frames are dropped on a bad stop bit or after TIMEOUT_CLKS idle cycles between bytes.
module uart_stream_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 86800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         uart_rx,
    output logic [511:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         frame_err,
    output logic         timeout_err
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] TMO     = IW'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t         r_state;
    logic           r_rx_meta;
    logic           r_rx_s;
    logic [TW-1:0]  r_timer;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [5:0]     r_cnt;
    logic [IW-1:0]  r_idle;
    logic [511:0]   r_asm;
    logic           w_rx_active;

    // WAIT_HIGH is excluded so busy drops together with frame_err.
    assign w_rx_active = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    assign busy        = w_rx_active || (r_cnt != 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_asm       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_rx_meta   <= uart_rx;
            r_rx_s      <= r_rx_meta;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A start edge takes priority over an expiring timeout.
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_timer <= '0;
                        r_idle  <= '0;
                    end else if (r_cnt == 6'd0) begin
                        r_idle <= '0;
                    end else if (r_idle == TMO) begin
                        r_cnt       <= '0;
                        r_idle      <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                        else                   r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        if (r_rx_s) begin
                            r_state                 <= S_IDLE;
                            r_asm[{r_cnt, 3'b000} +: 8] <= r_shift;
                            r_cnt                   <= r_cnt + 1'b1;
                            if (r_cnt == 6'd63) begin
                                data_out   <= {r_shift, r_asm[503:0]};
                                data_valid <= 1'b1;
                            end
                        end else begin
                            r_state   <= S_WAIT_HIGH;
                            r_cnt     <= '0;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stream_rx.sv
// Directed bench for uart_stream_rx: drives 8N1 bytes on the pin and checks frames, errors and timing.
module tb_uart_stream_rx;

    localparam int CPB = 16;
    localparam int TMO = 400;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         uart_rx = 1'b1;
    logic [511:0] data_out;
    logic         data_valid, busy, frame_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_terr = 0, n_bad = 0;
    int last_v_cyc = 0, last_t_cyc = 0;
    logic [511:0] prev_dout = '0;
    logic         rst_d = 1'b1;

    uart_stream_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Event counters; data_out may only change on a data_valid cycle or right after reset.
    always @(negedge clk) begin
        if (data_valid) begin n_valid++; last_v_cyc = cyc; end
        if (frame_err) n_ferr++;
        if (timeout_err) begin n_terr++; last_t_cyc = cyc; end
        if (!data_valid && !rst_d && data_out !== prev_dout) n_bad++;
        prev_dout = data_out;
        rst_d = rst;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(CPB); end
        uart_rx = stop_bit; tick(CPB);
        uart_rx = 1'b1;
    endtask

    function automatic logic [7:0] bval(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'hA5;
            2:       return 8'h5A;
            3:       return 8'(i * 3 + 1);
            4:       return 8'(8'hFF - i);
            default: return 8'(i) ^ 8'h55;
        endcase
    endfunction

    function automatic logic [511:0] frame(input int kind);
        logic [511:0] f;
        for (int i = 0; i < 64; i++) f[i*8 +: 8] = bval(kind, i);
        return f;
    endfunction

    task automatic send_frame(input int kind);
        for (int i = 0; i < 64; i++) send_byte(bval(kind, i), 1'b1);
    endtask

    initial begin
        int v0, f0, t0, c0, end_cyc;
        logic [511:0] fa, fb, exp;

        tick(3);
        chk("reset_data_out", data_out, '0);
        chk("reset_valid", 512'(data_valid), '0);
        chk("reset_busy", 512'(busy), '0);
        chk("reset_frame_err", 512'(frame_err), '0);
        chk("reset_timeout_err", 512'(timeout_err), '0);
        rst = 1'b0;
        tick(4);

        // 1: back-to-back frame 0x00..0x3F
        v0 = n_valid; f0 = n_ferr; t0 = n_terr;
        send_frame(0);
        tick(2);
        exp = frame(0);
        chk("t1_valid_count", 512'(n_valid - v0), 512'(1));
        chk("t1_byte0", 512'(data_out[7:0]), 512'(8'h00));
        chk("t1_byte63", 512'(data_out[511:504]), 512'(8'h3F));
        chk("t1_frame", data_out, exp);
        chk("t1_no_errors", 512'((n_ferr - f0) + (n_terr - t0)), '0);
        chk("t1_busy_low", 512'(busy), '0);

        // 2: short low glitch is ignored, then a full 0xA5 frame
        v0 = n_valid; f0 = n_ferr;
        uart_rx = 1'b0; tick(4); uart_rx = 1'b1; tick(3 * CPB);
        chk("t2_glitch_busy", 512'(busy), '0);
        chk("t2_glitch_no_err", 512'(n_ferr - f0), '0);
        send_frame(1);
        tick(2);
        chk("t2_valid_count", 512'(n_valid - v0), 512'(1));
        chk("t2_frame", data_out, {64{8'hA5}});

        // 3: bad stop bit held low as a break
        v0 = n_valid; f0 = n_ferr; t0 = n_terr;
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h80), 1'b1);
        send_byte(8'hC3, 1'b0);
        uart_rx = 1'b0; tick(49 * CPB);
        uart_rx = 1'b1; tick(3 * CPB);
        chk("t3_one_frame_err", 512'(n_ferr - f0), 512'(1));
        chk("t3_no_valid", 512'(n_valid - v0), '0);
        chk("t3_no_timeout", 512'(n_terr - t0), '0);
        chk("t3_busy_low", 512'(busy), '0);
        send_frame(2);
        tick(2);
        chk("t3_frame", data_out, {64{8'h5A}});

        // 4: partial frame dropped by timeout
        v0 = n_valid; t0 = n_terr;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
        end_cyc = cyc;
        chk("t4_busy_partial", 512'(busy), 512'(1));
        tick(500);
        chk("t4_one_timeout", 512'(n_terr - t0), 512'(1));
        chk("t4_timeout_time", 512'((last_t_cyc - end_cyc >= 390) && (last_t_cyc - end_cyc <= 400)), 512'(1));
        chk("t4_busy_low", 512'(busy), '0);
        chk("t4_data_held", data_out, {64{8'h5A}});
        chk("t4_no_valid", 512'(n_valid - v0), '0);
        send_frame(3);
        tick(2);
        chk("t4_frame", data_out, frame(3));

        // 5: reset during data bit 3 of byte 20
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1);
        uart_rx = 1'b0; tick(CPB);
        uart_rx = 1'b0; tick(CPB);
        uart_rx = 1'b1; tick(CPB);
        uart_rx = 1'b0; tick(CPB);
        uart_rx = 1'b1; tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_data_out", data_out, '0);
        chk("t5_rst_busy", 512'(busy), '0);
        chk("t5_rst_pulses", 512'({data_valid, frame_err, timeout_err}), '0);
        tick(2 * CPB);
        v0 = n_valid;
        fa = frame(4);
        send_frame(4);
        tick(2);
        chk("t5_valid_count", 512'(n_valid - v0), 512'(1));
        chk("t5_frame_a", data_out, fa);

        // 6: frame B follows A; A must be held until B's final byte completes
        fb = frame(5);
        for (int i = 0; i < 63; i++) send_byte(bval(5, i), 1'b1);
        chk("t6_hold_a", data_out, fa);
        chk("t6_no_early_valid", 512'(n_valid - v0), 512'(1));
        c0 = cyc;
        send_byte(bval(5, 63), 1'b1);
        tick(2);
        chk("t6_valid_count", 512'(n_valid - v0), 512'(2));
        chk("t6_valid_latency", 512'(last_v_cyc - c0), 512'(155));
        chk("t6_frame_b", data_out, fb);
        chk("no_stray_data_out_change", 512'(n_bad), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_stream_rx.md
# uart_stream_rx

Receive side of the 512-bit UART streaming link. Deserialises 64 consecutive 8N1 UART bytes and reassembles them little-endian into one 512-bit word. Byte 0 received lands in bits [7:0], and byte 63 lands in bits [511:504]. Sits between the board RX pin and the ChaCha20 input path, and is the exact inverse of the stream transmitter's byte ordering.

## Interface
Parameters:
- CLKS_PER_BIT, default 868 — clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- TIMEOUT_CLKS, default 86800 — idle cycles allowed between bytes of a partial frame before that frame is discarded.

Ports:
- clk — input, 1 — system clock.
- rst — input, 1 — synchronous, active-high reset.
- uart_rx — input, 1 — asynchronous serial line; idles high.
- data_out — output, 512 — last completed frame, little-endian; held until the next frame completes.
- data_valid — output, 1 — one-cycle pulse when data_out updates.
- busy — output, 1 — high while a byte is being received or a partial frame is held (byte_count ≠ 0).
- frame_err — output, 1 — one-cycle pulse on a bad stop bit.
- timeout_err — output, 1 — one-cycle pulse when a partial frame is dropped by timeout.

## Operation
**Input conditioning**
- uart_rx passes through a 2-FF synchroniser (rx_s). The synchroniser resets to 1.

**Byte receiver FSM**
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rx_s == 0, clear the bit timer and go to START.
- START: after CLKS_PER_BIT/2 cycles, sample rx_s.
  - If 0, go to DATA with bit_idx = 0.
  - If 1, this is a glitch: return to IDLE with no error.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift bit bit_idx, LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1: the byte is good; go to IDLE. Returning mid-stop-bit lets back-to-back bytes be caught.
  - If 0: pulse frame_err, discard the byte, clear byte_count to 0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. A held-low break produces exactly one frame_err.

**Frame assembly**
- A good byte is written to asm_reg[byte_count*8 +: 8] and byte_count (6 bits) increments.
- When byte 63 is good:
  - data_out ← the completed asm_reg, including byte 63.
  - data_valid pulses.
  - byte_count wraps to 0.
- Bytes are never partially exposed; data_out changes only on frame completion.

**Timeout**
- The idle counter runs only when the FSM is in IDLE and byte_count ≠ 0. It clears on any start detection or when byte_count == 0.
- When the counter reaches TIMEOUT_CLKS:
  - byte_count ← 0 and asm_reg is treated as empty.
  - timeout_err pulses once.
  - data_out is unchanged.

**Reset** (synchronous, any state, mid-byte included):
- FSM → IDLE; byte_count, timers, asm_reg and data_out cleared to 0.
- data_valid, frame_err and timeout_err go to 0; busy goes to 0.

## Timing
- Sample points, in cycles after rx_s first goes low:
  - start bit at CLKS_PER_BIT/2;
  - data bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Pin-to-rx_s latency is 2 cycles.
- Byte 63's stop sample is at cycle t. At t+1, data_out is updated and data_valid = 1 for exactly one cycle.
- frame_err is high at the cycle after the bad stop sample, for one cycle.
- timeout_err is high for one cycle, at the cycle after the counter hits TIMEOUT_CLKS.
- busy rises the cycle after the start is detected and stays high while byte_count ≠ 0. It falls with the data_valid, frame_err or timeout_err cycle once byte_count returns to 0.
- Simultaneous events:
  - A timeout and a start edge in the same cycle: the start wins and the counter clears.
  - frame_err on byte 63: no data_valid, and data_out keeps the previous frame.

## Test plan
Bench uses CLKS_PER_BIT = 16 and TIMEOUT_CLKS = 400.

1. **Back-to-back frame:** send 64 bytes 0x00..0x3F with no gaps → one data_valid pulse; data_out[7:0] = 0x00, data_out[511:504] = 0x3F; no errors.
2. **Glitch:** drive a 4-cycle low glitch on an idle line → no byte accepted, no error, byte_count stays 0; then a full frame of 0xA5 bytes → data_out = {64{8'hA5}}.
3. **Bad stop bit:** send 10 bytes, then an 11th byte with stop bit = 0 held low 50 bit-times → exactly one frame_err and no data_valid. Then send 64 bytes of 0x5A → data_out = {64{8'h5A}}; the partial bytes are not included.
4. **Timeout:** send 5 bytes, then idle for 500 cycles → one timeout_err about 400 cycles after the 5th stop sample; busy falls; data_out unchanged. The next full frame assembles correctly from byte 0.
5. **Reset mid-byte:** assert rst for 1 cycle during data bit 3 of byte 20 → all outputs 0 the next cycle. A new 64-byte frame completes normally.
6. **Two frames:** send frame A, then frame B → data_out holds A between the two data_valid pulses and switches to B exactly one cycle after B's final stop sample.
